// File: rtl/ocr_pkg.sv
// Shared definitions for the OCR template matcher: default sizes, score ceiling and FSM encoding.
package ocr_pkg;

  localparam int NUM_TEMPLATES_DEF = 10;
  localparam int PIXELS_DEF        = 256;
  localparam int DATA_W_DEF        = 8;
  localparam int SCORE_W_DEF       = 16;

  localparam logic [SCORE_W_DEF-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CLOSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ocr_abs_diff.sv
// Unsigned absolute difference |a - b| of two pixel values, purely combinational.
module ocr_abs_diff
  import ocr_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/ocr_match_sequencer.sv
// Walks every template in memory, accumulates its SAD against the test image and reports the best match.
// Build option: define OCR_EARLY_ABORT_EN to stop scanning a template once it can no longer win.
module ocr_match_sequencer
  import ocr_pkg::*;
#(
  parameter int NUM_TEMPLATES = NUM_TEMPLATES_DEF,
  parameter int PIXELS        = PIXELS_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic               ip_clk,
  input  logic               ip_rst_n,
  input  logic               ip_start,
  input  logic [DATA_W-1:0]  ip_template_data,
  input  logic [DATA_W-1:0]  ip_test_data,
  output logic [3:0]         op_address,
  output logic [7:0]         op_count,
  output logic               op_busy,
  output logic               op_done,
  output logic [3:0]         op_digit,
  output logic [SCORE_W-1:0] op_score
);

  localparam logic [7:0] LAST_PIXEL    = 8'(PIXELS - 1);
  localparam logic [3:0] LAST_TEMPLATE = 4'(NUM_TEMPLATES - 1);

  state_t               state_reg, state_next;
  logic [3:0]           t_reg, t_next;
  logic [7:0]           p_reg, p_next;
  logic [SCORE_W-1:0]   acc_reg, acc_next;
  logic [SCORE_W-1:0]   best_reg, best_next;
  logic [3:0]           best_idx_reg, best_idx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [3:0]           digit_reg, digit_next;
  logic [SCORE_W-1:0]   score_reg, score_next;

  logic [DATA_W-1:0]    pixel_diff;
  logic [SCORE_W-1:0]   acc_sum;

  ocr_abs_diff #(.W(DATA_W)) u_abs_diff (
    .a (ip_template_data),
    .b (ip_test_data),
    .y (pixel_diff)
  );

  assign acc_sum = acc_reg + SCORE_W'(pixel_diff);

  always_comb begin
    state_next    = state_reg;
    t_next        = t_reg;
    p_next        = p_reg;
    acc_next      = acc_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    digit_next    = digit_reg;
    score_next    = score_reg;
    done_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (ip_start) begin
          state_next = ST_SCAN;
          t_next     = '0;
          p_next     = '0;
          acc_next   = '0;
          best_next  = '1;
        end
      end
      ST_SCAN: begin
        acc_next = acc_sum;
`ifdef OCR_EARLY_ABORT_EN
        // A partial sum already at or above the best can never win; the pixel index stays put.
        if (acc_sum >= best_reg || p_reg == LAST_PIXEL) begin
          state_next = ST_CLOSE;
        end else begin
          p_next = p_reg + 8'd1;
        end
`else
        if (p_reg == LAST_PIXEL) begin
          state_next = ST_CLOSE;
        end else begin
          p_next = p_reg + 8'd1;
        end
`endif
      end
      ST_CLOSE: begin
        // Strict compare so an equal score keeps the earlier (lower) template index.
        if (acc_reg < best_reg) begin
          best_next     = acc_reg;
          best_idx_next = t_reg;
        end
        if (t_reg == LAST_TEMPLATE) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SCAN;
          t_next     = t_reg + 4'd1;
          p_next     = '0;
          acc_next   = '0;
        end
      end
      ST_DONE: begin
        digit_next = best_idx_reg;
        score_next = best_reg;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_reg    <= ST_IDLE;
      t_reg        <= '0;
      p_reg        <= '0;
      acc_reg      <= '0;
      best_reg     <= '1;
      best_idx_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      digit_reg    <= '0;
      score_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      t_reg        <= t_next;
      p_reg        <= p_next;
      acc_reg      <= acc_next;
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      digit_reg    <= digit_next;
      score_reg    <= score_next;
    end
  end

  assign op_address = t_reg;
  assign op_count   = p_reg;
  assign op_busy    = busy_reg;
  assign op_done    = done_reg;
  assign op_digit   = digit_reg;
  assign op_score   = score_reg;

endmodule

// File: tb/tb_ocr_match_sequencer.sv
// Scoreboard bench for ocr_match_sequencer: directed and random template sets against a SAD reference model.
module tb_ocr_match_sequencer;
  import ocr_pkg::*;

  localparam int NT  = 10;
  localparam int PIX = 256;

  logic        ip_clk;
  logic        ip_rst_n;
  logic        ip_start;
  logic [7:0]  ip_template_data;
  logic [7:0]  ip_test_data;
  logic [3:0]  op_address;
  logic [7:0]  op_count;
  logic        op_busy;
  logic        op_done;
  logic [3:0]  op_digit;
  logic [15:0] op_score;

  ocr_match_sequencer dut (
    .ip_clk           (ip_clk),
    .ip_rst_n         (ip_rst_n),
    .ip_start         (ip_start),
    .ip_template_data (ip_template_data),
    .ip_test_data     (ip_test_data),
    .op_address       (op_address),
    .op_count         (op_count),
    .op_busy          (op_busy),
    .op_done          (op_done),
    .op_digit         (op_digit),
    .op_score         (op_score)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  // Memory model: combinational reads at the address the DUT drives.
  logic [7:0] tmpl [0:NT-1][0:PIX-1];
  logic [7:0] timg [0:PIX-1];

  always_comb begin
    ip_test_data     = timg[op_count];
    ip_template_data = 8'h00;
    if (int'(op_address) < NT) ip_template_data = tmpl[op_address][op_count];
  end

  longint cyc = 0;
  always @(posedge ip_clk) cyc <= cyc + 1;

  typedef struct {
    int     digit;
    int     score;
    longint when;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: score every template in full (or until it can no longer win), keep strict minimum.
  task automatic model(output int dig, output int score, output int lat);
    int best;
    best  = int'(SCORE_MAX);
    dig   = 0;
    lat   = 1;
    for (int t = 0; t < NT; t++) begin
      int acc;
      int n;
      acc = 0;
      n   = 0;
      for (int p = 0; p < PIX; p++) begin
        int a;
        int b;
        a = int'(tmpl[t][p]);
        b = int'(timg[p]);
        acc += (a > b) ? a - b : b - a;
        n++;
`ifdef OCR_EARLY_ABORT_EN
        if (acc >= best) break;
`endif
      end
      lat += n + 1;
      if (acc < best) begin
        best = acc;
        dig  = t;
      end
    end
    score = best;
  endtask

  // Monitor: pops the next expectation whenever the DUT signals a result.
  always @(negedge ip_clk) begin
    if (ip_rst_n && op_done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("digit", op_digit, e.digit);
        chk("score", op_score, e.score);
        chk("done_cycle", cyc, e.when);
      end
    end
  end

`ifndef OCR_EARLY_ABORT_EN
  // Address walk: each run must present (t,p) in strict raster order, every pair once.
  int seq_t, seq_p, seq_n;
  bit seq_err, prev_busy;
  always @(negedge ip_clk) begin
    if (!ip_rst_n) begin
      prev_busy = 1'b0;
      seq_n     = 0;
      seq_err   = 1'b0;
    end else begin
      if (op_busy && !prev_busy) begin
        seq_err = (op_address != 4'd0) || (op_count != 8'd0);
        seq_t   = int'(op_address);
        seq_p   = int'(op_count);
        seq_n   = 1;
      end else if (op_busy && (int'(op_address) != seq_t || int'(op_count) != seq_p)) begin
        int nt;
        int np;
        nt = (seq_p == PIX - 1) ? seq_t + 1 : seq_t;
        np = (seq_p == PIX - 1) ? 0 : seq_p + 1;
        if (int'(op_address) != nt || int'(op_count) != np) seq_err = 1'b1;
        seq_t = int'(op_address);
        seq_p = int'(op_count);
        seq_n++;
      end
      if (op_done) begin
        chk("addr_seq_order", seq_err, 0);
        chk("addr_seq_len", seq_n, NT * PIX);
        seq_n = 0;
      end
      prev_busy = op_busy;
    end
  end
`endif

  task automatic issue_start();
    int d, s, l;
    exp_t e;
    model(d, s, l);
    @(negedge ip_clk);
    ip_start = 1'b1;
    e.digit = d;
    e.score = s;
    e.when  = cyc + 1 + l;
    q.push_back(e);
    $display("start: expect digit=%0d score=%0d latency=%0d", d, s, l);
    @(negedge ip_clk);
    ip_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 5000) begin
      @(posedge ip_clk);
      k++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic fill_base();
    for (int p = 0; p < PIX; p++) timg[p] = 8'(p);
  endtask

  task automatic fill_random(input int mode);
    for (int p = 0; p < PIX; p++) timg[p] = 8'($urandom_range(0, 255));
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < PIX; p++)
        if (mode == 0) tmpl[t][p] = 8'($urandom_range(0, 255));
        else tmpl[t][p] = timg[p] + 8'($urandom_range(0, 3));
    if (mode == 2) begin
      int a, b;
      a = int'($urandom_range(0, NT - 2));
      b = int'($urandom_range(a + 1, NT - 1));
      for (int p = 0; p < PIX; p++) tmpl[b][p] = tmpl[a][p];
    end
  endtask

  initial begin
    int target;
    ip_rst_n = 1'b0;
    ip_start = 1'b0;
    fill_base();
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < PIX; p++) tmpl[t][p] = 8'h00;
    repeat (3) @(negedge ip_clk);
    chk("rst_address", op_address, 0);
    chk("rst_count", op_count, 0);
    chk("rst_busy", op_busy, 0);
    chk("rst_done", op_done, 0);
    chk("rst_digit", op_digit, 0);
    chk("rst_score", op_score, 0);
    ip_rst_n = 1'b1;
    repeat (2) @(negedge ip_clk);

    // Template 7 matches exactly, others offset by 0x10.
    fill_base();
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < PIX; p++) tmpl[t][p] = (t == 7) ? timg[p] : timg[p] + 8'h10;
    target = done_cnt + 1;
    issue_start();
    wait_done(target);

    // Tie between templates 2 and 5.
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < PIX; p++)
        tmpl[t][p] = (t == 2 || t == 5) ? timg[p] : 8'($urandom_range(0, 255));
    target = done_cnt + 1;
    issue_start();
    wait_done(target);

    // Near-full-scale scores must not wrap.
    for (int p = 0; p < PIX; p++) timg[p] = 8'h00;
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < PIX; p++) tmpl[t][p] = (t == 9) ? 8'hFE : 8'hFF;
    target = done_cnt + 1;
    issue_start();
    wait_done(target);

    // Start pulse while busy is ignored.
    fill_random(1);
    target = done_cnt + 1;
    issue_start();
    repeat (498) @(negedge ip_clk);
    ip_start = 1'b1;
    @(negedge ip_clk);
    ip_start = 1'b0;
    wait_done(target);
    repeat (5) @(negedge ip_clk);
    chk("single_done", done_cnt, target);

    // Reset mid-run abandons the result.
    fill_random(0);
    issue_start();
    repeat (998) @(negedge ip_clk);
    chk("busy_mid_run", op_busy, 1);
    ip_rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_busy", op_busy, 0);
    chk("midrst_count", op_count, 0);
    chk("midrst_address", op_address, 0);
    chk("midrst_done", op_done, 0);
    chk("midrst_score", op_score, 0);
    repeat (2) @(negedge ip_clk);
    ip_rst_n = 1'b1;
    @(negedge ip_clk);
    target = done_cnt + 1;
    issue_start();
    wait_done(target);

    // Template 0 exact, all others differ on every byte.
    fill_base();
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < PIX; p++) tmpl[t][p] = (t == 0) ? timg[p] : timg[p] ^ 8'h01;
    target = done_cnt + 1;
    issue_start();
    wait_done(target);

    // Start held high: back-to-back runs.
    fill_random(2);
    begin
      int d, s, l;
      exp_t e;
      model(d, s, l);
      @(negedge ip_clk);
      ip_start = 1'b1;
      e.digit = d;
      e.score = s;
      e.when  = cyc + 1 + l;
      q.push_back(e);
      e.when  = cyc + 1 + l + 1 + l;
      q.push_back(e);
      $display("held start: expect two results digit=%0d score=%0d", d, s);
      target = done_cnt + 1;
      wait_done(target);
      @(negedge ip_clk);
      ip_start = 1'b0;
      target = done_cnt + 1;
      wait_done(target);
    end

    // Random template sets.
    for (int r = 0; r < 4; r++) begin
      fill_random(r % 3);
      target = done_cnt + 1;
      issue_start();
      wait_done(target);
    end

    repeat (5) @(negedge ip_clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
